// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec -- request/acknowledge ALU execution unit.
//
// Accepts one operation at a time. Single-cycle operations complete in the
// cycle after accept. MUL runs an iterative shift-add multiply, one
// multiplier bit per cycle, for WIDTH cycles. Results, the zero flag and the
// illegal-code flag are held until the next completion.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      asynchronous active-high reset
//   valid_i    request present
//   ready_o    unit idle, request will be accepted on the next edge
//   ctrl_i     4-bit ALU control code
//   src1_i     operand 1 (multiplicand for MUL, return address for JAL)
//   src2_i     operand 2 (multiplier for MUL)
//   done_o     one-cycle completion pulse
//   result_o   registered result
//   zero_o     result_o == 0
//   illegal_o  last completed code was not a supported operation
//
// States:
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a request, ready_o high
//   MUL     | shift-add multiply in progress, one multiplier bit per cycle
//   DONE    | result valid, done_o high for this single cycle
// ---------------------------------------------------------------------------
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_JAL = 4'd8;
  localparam logic [3:0] OP_NOR = 4'd12;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;
  logic [WIDTH-1:0] prod_step;
  logic             mul_last;

  assign accept = valid_i && (state_q == ST_IDLE);

  // Signed compare directly on the operands avoids the overflow trap of
  // inspecting the sign of src1 - src2.
  assign slt_bit = $signed(src1_i) < $signed(src2_i);

  // Single-cycle datapath, evaluated on the live inputs at accept.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (ctrl_i)
      OP_AND: alu_res = src1_i & src2_i;
      OP_OR:  alu_res = src1_i | src2_i;
      OP_ADD: alu_res = src1_i + src2_i;
      OP_SUB: alu_res = src1_i - src2_i;
      OP_SLT: alu_res[0] = slt_bit;
      OP_JAL: alu_res = src1_i;
      OP_NOR: alu_res = ~(src1_i | src2_i);
      OP_MUL: alu_res = '0;
      default: begin
        alu_res     = '0;
        alu_illegal = 1'b1;
      end
    endcase
  end

  // Shift-add step: the multiplicand is pre-shifted each cycle, so the
  // current multiplier LSB selects whether it is added in.
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ctrl_i == OP_MUL) begin
            mcand_d  = src1_i;
            mplier_d = src2_i;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            result_d  = alu_res;
            illegal_d = alu_illegal;
            state_d   = ST_DONE;
          end
        end
      end

      ST_MUL: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_last) begin
          // Only the finished product is exposed on result_o.
          result_d  = prod_step;
          illegal_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign ready_o   = (state_q == ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign result_o  = result_q;
  assign zero_o    = (result_q == '0);
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_exec -- self-checking bench for alu_exec.
//
// A behavioural model (latency countdown + arithmetic reference) predicts
// ready/done/result/zero/illegal every cycle; a compare process checks the
// DUT on each falling edge. Directed scenarios add literal expectations,
// followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_alu_exec;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic [3:0]   ctrl_i = '0;
  logic [W-1:0] src1_i = '0;
  logic [W-1:0] src2_i = '0;
  logic         ready_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         illegal_o;

  alu_exec #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ctrl_i   (ctrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .done_o   (done_o),
    .result_o (result_o),
    .zero_o   (zero_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: returns {illegal, result}.
  function automatic logic [W:0] ref_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    case (c)
      4'd0:  return {1'b0, a & b};
      4'd1:  return {1'b0, a | b};
      4'd2:  return {1'b0, a + b};
      4'd3:  begin p = a * b; return {1'b0, p}; end
      4'd6:  return {1'b0, a - b};
      4'd7:  return {1'b0, ($signed(a) < $signed(b)) ? W'(1) : W'(0)};
      4'd8:  return {1'b0, a};
      4'd12: return {1'b0, ~(a | b)};
      default: return {1'b1, {W{1'b0}}};
    endcase
  endfunction

  // Model: m_left counts the cycles until the completion cycle (1 = done now).
  int           m_left = 0;
  logic [W-1:0] m_res  = '0;
  logic         m_ill  = 1'b0;
  logic [W-1:0] m_pres = '0;
  logic         m_pill = 1'b0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_left <= 0;
      m_res  <= '0;
      m_ill  <= 1'b0;
    end else if (m_left > 1) begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_res <= m_pres;
        m_ill <= m_pill;
      end
    end else if (m_left == 1) begin
      m_left <= 0;
    end else if (valid_i) begin
      if (ctrl_i == 4'd3) begin
        m_left <= W + 1;
        {m_pill, m_pres} <= ref_op(ctrl_i, src1_i, src2_i);
      end else begin
        m_left <= 1;
        {m_ill, m_res} <= ref_op(ctrl_i, src1_i, src2_i);
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("ready",   W'(ready_o),   W'(m_left == 0));
      chk("done",    W'(done_o),    W'(m_left == 1));
      chk("result",  result_o,      m_res);
      chk("zero",    W'(zero_o),    W'(m_res == '0));
      chk("illegal", W'(illegal_o), W'(m_ill));
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) chk("ready_timeout", W'(ready_o), W'(1));
  endtask

  // Issue one request from a falling edge; returns the cycle count to done_o
  // and the number of not-ready cycles seen. Ends on the done_o falling edge.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit poke, output int lat, output int busy);
    wait_ready();
    valid_i = 1'b1;
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
    @(negedge clk_i);
    valid_i = 1'b0;
    ctrl_i  = 4'($urandom);
    src1_i  = $urandom;
    src2_i  = $urandom;
    lat  = 1;
    busy = ready_o ? 0 : 1;
    while (!done_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
      if (!ready_o) busy++;
      if (poke) valid_i = (lat == 10);
    end
    valid_i = 1'b0;
    if (!done_o) chk("done_timeout", W'(done_o), W'(1));
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] codes [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd12, 4'd4, 4'd5, 4'd9, 4'd15};

  initial begin
    int lat, busy;
    bit seen_done;

    // Reset state
    @(negedge clk_i);
    chk("rst_ready",   W'(ready_o),   W'(1));
    chk("rst_done",    W'(done_o),    W'(0));
    chk("rst_result",  result_o,      W'(0));
    chk("rst_zero",    W'(zero_o),    W'(1));
    chk("rst_illegal", W'(illegal_o), W'(0));
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    chk_en = 1'b1;

    // ADD wrap
    issue(4'd2, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, busy);
    chk("add_lat",     W'(lat),       W'(1));
    chk("add_result",  result_o,      32'h0);
    chk("add_zero",    W'(zero_o),    W'(1));
    chk("add_illegal", W'(illegal_o), W'(0));

    // SLT across overflow
    issue(4'd7, 32'h8000_0000, 32'h1, 1'b0, lat, busy);
    chk("slt1_result", result_o, 32'h1);
    issue(4'd7, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, busy);
    chk("slt2_result", result_o, 32'h0);

    // MUL with an ignored mid-operation request
    issue(4'd3, 32'h0001_2345, 32'h0001_0000, 1'b1, lat, busy);
    chk("mul_lat",    W'(lat),  W'(33));
    chk("mul_busy",   W'(busy), W'(33));
    chk("mul_result", result_o, 32'h2345_0000);
    @(negedge clk_i);
    chk("mul_no_queue_ready", W'(ready_o), W'(1));
    chk("mul_no_queue_done",  W'(done_o),  W'(0));

    // Illegal code then NOR
    issue(4'd5, 32'h3, 32'h0, 1'b0, lat, busy);
    chk("ill_lat",     W'(lat),       W'(1));
    chk("ill_result",  result_o,      32'h0);
    chk("ill_illegal", W'(illegal_o), W'(1));
    issue(4'd12, 32'h0, 32'h0, 1'b0, lat, busy);
    chk("nor_result",  result_o,      32'hFFFF_FFFF);
    chk("nor_illegal", W'(illegal_o), W'(0));

    // Reset at cycle 10 of a MUL
    wait_ready();
    valid_i = 1'b1;
    ctrl_i  = 4'd3;
    src1_i  = 32'h0000_0007;
    src2_i  = 32'h0000_0009;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("abort_ready",  W'(ready_o), W'(1));
    chk("abort_result", result_o,    32'h0);
    chk("abort_done",   W'(done_o),  W'(0));
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o) seen_done = 1'b1;
    end
    chk("abort_no_done", W'(seen_done), W'(0));
    issue(4'd8, 32'h0040_0010, 32'h1234_5678, 1'b0, lat, busy);
    chk("jal_lat",    W'(lat),  W'(1));
    chk("jal_result", result_o, 32'h0040_0010);

    // Back-to-back with valid held high
    wait_ready();
    valid_i = 1'b1;
    ctrl_i  = 4'd0;
    src1_i  = 32'hF0F0_1234;
    src2_i  = 32'h0FF0_FF00;
    @(negedge clk_i);
    chk("b2b_and_done",   W'(done_o), W'(1));
    chk("b2b_and_result", result_o,   32'h00F0_1200);
    ctrl_i = 4'd1;
    src1_i = 32'h1200_0003;
    src2_i = 32'h0000_0030;
    @(negedge clk_i);
    chk("b2b_gap_done",   W'(done_o),  W'(0));
    chk("b2b_gap_ready",  W'(ready_o), W'(1));
    chk("b2b_gap_result", result_o,    32'h00F0_1200);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("b2b_or_done",   W'(done_o), W'(1));
    chk("b2b_or_result", result_o,   32'h1200_0033);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_i);
      valid_i = ($urandom_range(0, 99) < 60);
      ctrl_i  = codes[$urandom_range(0, 11)];
      src1_i  = rnd_opnd();
      src2_i  = rnd_opnd();
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_i = 1'b1;
        @(negedge clk_i);
        #2 rst_i = 1'b0;
      end
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (40) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have the following parameter (name, default, meaning): WIDTH, 32, operand/result width in bits.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  request present.
- ready_o  output  1  block can accept a request.
- ctrl_i  input  4  ALU control code from the ALU controller.
- src1_i  input  WIDTH  operand 1.
- src2_i  input  WIDTH  operand 2.
- done_o  output  1  result valid; one-cycle pulse.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  result_o == 0.
- illegal_o  output  1  last completed code was unsupported.

Function
REQ-003 The block SHALL decode ctrl_i as follows: 0 AND, 1 OR, 2 ADD, 3 MUL, 6 SUB, 7 SLT, 8 JAL, 12 NOR; every other code SHALL be illegal.
REQ-004 The block SHALL implement a three-state FSM: IDLE, MUL, DONE.
REQ-005 ready_o SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge where valid_i && ready_o.
REQ-006 The block SHALL capture ctrl_i, src1_i and src2_i at accept; input changes after accept SHALL have no effect on the operation.
REQ-007 valid_i asserted in MUL or DONE SHALL be ignored, with no queuing.
REQ-008 For a non-MUL code, accept SHALL move IDLE->DONE, with result_o registered on the accept edge.
REQ-009 done_o SHALL be 1 exactly during the DONE cycle; DONE SHALL always return to IDLE after one cycle.
- Latency: done_o high in the cycle immediately after accept.
REQ-010 Arithmetic rules:
- ADD/SUB: wrap modulo 2^WIDTH; no overflow flag.
- AND/OR/NOR: bitwise.
- SLT: result 1 if src1 < src2 as signed two's complement, else 0; correct even when src1-src2 overflows.
- JAL: result = src1, which carries the return address.
REQ-011 MUL SHALL be iterative shift-add over exactly WIDTH cycles in state MUL.
- Product register and iteration counter cleared on accept.
- One multiplier bit consumed per cycle, LSB first.
- After the WIDTH-th iteration, transition to DONE with result_o = low WIDTH bits of src1*src2 (unsigned, equal to the signed low half).
- Latency: done_o high WIDTH+1 cycles after accept.
REQ-012 For an illegal code, the block SHALL follow the single-cycle path with result_o=0 and illegal_o=1; for any legal code, illegal_o=0 at completion.
REQ-013 zero_o SHALL be combinationally equal to (result_o == 0).
REQ-014 result_o, zero_o and illegal_o SHALL hold their values from the last completion until the next completion; intermediate MUL partial products SHALL NOT appear on result_o.
REQ-015 Back-to-back operation: a new request is accepted earliest in the IDLE cycle after DONE, giving a peak throughput of one single-cycle op per 2 cycles.

Reset
REQ-016 While rst_i=1, regardless of clock, the block SHALL hold the FSM in IDLE and drive result_o=0, done_o=0, illegal_o=0, counter=0 and product=0; zero_o SHALL therefore be 1 and ready_o SHALL be 1.
REQ-017 Reset asserted mid-MUL or in DONE SHALL abort the operation with no done_o pulse; the first accept after release SHALL behave as from power-up.

Verification
REQ-018 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- ADD: ctrl=2, src1=0xFFFFFFFF, src2=1 -> done_o next cycle, result_o=0, zero_o=1, illegal_o=0.
- SLT overflow: ctrl=7, src1=0x80000000, src2=1 -> result_o=1; then src1=0x7FFFFFFF, src2=0xFFFFFFFF -> result_o=0.
- MUL: ctrl=3, src1=0x00012345, src2=0x00010000 -> ready_o=0 for 33 cycles, done_o at accept+33, result_o=0x23450000; valid_i pulsed mid-MUL is ignored.
- Illegal code: ctrl=5, src1=3 -> done_o next cycle, result_o=0, illegal_o=1; a following NOR with src1=0, src2=0 -> result_o=0xFFFFFFFF, illegal_o=0.
- Reset at cycle 10 of a MUL -> ready_o=1, result_o=0 immediately, no done_o pulse; a following ctrl=8, src1=0x00400010 -> result_o=0x00400010.
- Back-to-back: valid_i held high with AND, then OR -> accepts 2 cycles apart, done_o pulses alternate, and result_o holds between completions.
